// File: rtl/instr_tracer_pkg.sv
// Shared types for the instruction trace capture path: trace classes, the buffered entry
// layout and the RISC-V opcode values the classifier decodes.
package instr_tracer_pkg;

    localparam int unsigned TRACE_PC_W = 64;
    localparam int unsigned MAX_PORTS  = 4;

    typedef enum logic [3:0] {
        CLS_OTHER = 4'd0,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_CSR,
        CLS_SYS,
        CLS_AMO,
        CLS_MULDIV,
        CLS_FP,
        CLS_SUBFP,
        CLS_COMPR,
        CLS_EXC
    } trace_class_e;

    typedef struct packed {
        logic [TRACE_PC_W-1:0] pc;
        logic [31:0]           instr;
        trace_class_e          cls;
        logic [1:0]            port;
        logic [63:0]           cycle;
    } trace_entry_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic [2:0] count_ones(input logic [MAX_PORTS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/instr_trace_classify.sv
// Combinational classifier: maps one retiring instruction (plus its exception flag) onto
// a trace class. Earlier checks take precedence over later ones.
module instr_trace_classify
    import instr_tracer_pkg::*;
(
    input  logic [31:0]  instr_i,
    input  logic         ex_i,
    output trace_class_e cls_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];

    always_comb begin
        cls_o = CLS_OTHER;
        if (ex_i) begin
            cls_o = CLS_EXC;
        end else if (instr_i[1:0] != 2'b11) begin
            cls_o = CLS_COMPR;
        end else begin
            case (w_opcode)
                OPC_LOAD:            cls_o = CLS_LOAD;
                OPC_STORE:           cls_o = CLS_STORE;
                OPC_BRANCH:          cls_o = CLS_BRANCH;
                OPC_JAL, OPC_JALR:   cls_o = CLS_JUMP;
                // funct3 == 0 covers ECALL/EBREAK/xRET/WFI/SFENCE.VMA; the rest are CSR ops
                OPC_SYSTEM:          cls_o = (w_funct3 != 3'd0) ? CLS_CSR : CLS_SYS;
                OPC_MISC_MEM:        cls_o = CLS_SYS;
                OPC_AMO:             cls_o = CLS_AMO;
                OPC_OP, OPC_OP32: begin
                    if (w_funct7 == FUNCT7_MULDIV) begin
                        cls_o = CLS_MULDIV;
                    end
                end
                OPC_CUSTOM0:         cls_o = CLS_SUBFP;
                OPC_LOAD_FP, OPC_STORE_FP, OPC_OP_FP,
                OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD:
                                     cls_o = CLS_FP;
                default:             cls_o = CLS_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/instr_trace_capture.sv
// Samples retiring instructions, classifies and cycle-stamps them, and buffers them in a
// multi-write FIFO drained over valid/ready. Commit is never stalled; overflow is counted.
module instr_trace_capture
    import instr_tracer_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned Depth         = 16,
    parameter int unsigned XLEN          = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NrCommitPorts-1:0]      commit_valid_i,
    input  logic [NrCommitPorts*32-1:0]   commit_instr_i,
    input  logic [NrCommitPorts*XLEN-1:0] commit_pc_i,
    input  logic [NrCommitPorts-1:0]      commit_ex_i,
    output logic                          trace_valid_o,
    input  logic                          trace_ready_i,
    output logic [XLEN-1:0]               trace_pc_o,
    output logic [31:0]                   trace_instr_o,
    output logic [3:0]                    trace_class_o,
    output logic [1:0]                    trace_port_o,
    output logic [63:0]                   trace_cycle_o,
    output logic [31:0]                   dropped_cnt_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;

    trace_entry_t  r_mem [Depth];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_cycle;
    logic [31:0]   r_dropped;

    trace_class_e       w_cls   [NrCommitPorts];
    trace_entry_t       w_entry [NrCommitPorts];
    logic [CW-1:0]      w_rank  [NrCommitPorts];
    logic [PW-1:0]      w_slot  [NrCommitPorts];
    logic [NrCommitPorts-1:0] w_push;
    logic [CW-1:0]      w_free;
    logic [CW-1:0]      w_valid_cnt;
    logic [CW-1:0]      w_pushed;
    logic [CW-1:0]      w_dropped_now;
    logic [32:0]        w_drop_sum;
    logic               w_pop;
    trace_entry_t       w_head;

    // Free space comes from the registered count only, so a same-cycle pop never helps a push.
    assign w_free        = CW'(Depth) - r_count;
    assign w_valid_cnt   = CW'(count_ones(MAX_PORTS'(commit_valid_i)));
    assign w_pushed      = (w_valid_cnt < w_free) ? w_valid_cnt : w_free;
    assign w_dropped_now = w_valid_cnt - w_pushed;
    assign w_drop_sum    = {1'b0, r_dropped} + 33'(w_dropped_now);
    assign w_pop         = trace_valid_o && trace_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < NrCommitPorts; gi++) begin : g_port
            localparam logic [NrCommitPorts-1:0] LOWER_MASK = NrCommitPorts'((1 << gi) - 1);

            instr_trace_classify u_classify (
                .instr_i (commit_instr_i[gi*32 +: 32]),
                .ex_i    (commit_ex_i[gi]),
                .cls_o   (w_cls[gi])
            );

            // Rank = number of valid commits on lower ports; it is this commit's slot offset.
            assign w_rank[gi] = CW'(count_ones(MAX_PORTS'(commit_valid_i & LOWER_MASK)));
            assign w_slot[gi] = r_wr_ptr + w_rank[gi][PW-1:0];
            assign w_push[gi] = commit_valid_i[gi] && (w_rank[gi] < w_free);

            assign w_entry[gi] = '{
                pc:    TRACE_PC_W'(commit_pc_i[gi*XLEN +: XLEN]),
                instr: commit_instr_i[gi*32 +: 32],
                cls:   w_cls[gi],
                port:  2'(gi),
                cycle: r_cycle
            };
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (!flush_i && w_push[p]) begin
                r_mem[w_slot[p]] <= w_entry[p];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_cycle   <= '0;
            r_dropped <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr  <= r_wr_ptr + w_pushed[PW-1:0];
                r_rd_ptr  <= r_rd_ptr + PW'(w_pop);
                r_count   <= r_count + w_pushed - CW'(w_pop);
                r_dropped <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
            end
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign trace_valid_o = (r_count != '0);
    assign empty_o       = (r_count == '0);
    assign full_o        = (r_count == CW'(Depth));
    assign dropped_cnt_o = r_dropped;

    // Data outputs read zero whenever nothing is buffered, including straight out of reset.
    assign trace_pc_o    = trace_valid_o ? w_head.pc[XLEN-1:0] : '0;
    assign trace_instr_o = trace_valid_o ? w_head.instr        : '0;
    assign trace_class_o = trace_valid_o ? 4'(w_head.cls)      : '0;
    assign trace_port_o  = trace_valid_o ? w_head.port         : '0;
    assign trace_cycle_o = trace_valid_o ? w_head.cycle        : '0;

endmodule

// File: tb/tb_instr_trace_capture.sv
// Scoreboard bench for instr_trace_capture: stimulus queues expected entries, a negedge
// monitor compares every popped head against the queue front.
module tb_instr_trace_capture;
    import instr_tracer_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [1:0]   commit_valid = '0;
    logic [63:0]  commit_instr = '0;
    logic [127:0] commit_pc = '0;
    logic [1:0]   commit_ex = '0;
    logic         trace_valid;
    logic         trace_ready = 1'b0;
    logic [63:0]  trace_pc;
    logic [31:0]  trace_instr;
    logic [3:0]   trace_class;
    logic [1:0]   trace_port;
    logic [63:0]  trace_cycle;
    logic [31:0]  dropped_cnt;
    logic         full;
    logic         empty;

    int n_checks = 0;
    int n_pass   = 0;
    int pop_idx  = 0;
    logic [63:0]  cyc;
    trace_entry_t exp_q[$];
    trace_entry_t mon_e;

    instr_trace_capture #(.NrCommitPorts(2), .Depth(16), .XLEN(64)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .commit_valid_i (commit_valid),
        .commit_instr_i (commit_instr),
        .commit_pc_i    (commit_pc),
        .commit_ex_i    (commit_ex),
        .trace_valid_o  (trace_valid),
        .trace_ready_i  (trace_ready),
        .trace_pc_o     (trace_pc),
        .trace_instr_o  (trace_instr),
        .trace_class_o  (trace_class),
        .trace_port_o   (trace_port),
        .trace_cycle_o  (trace_cycle),
        .dropped_cnt_o  (dropped_cnt),
        .full_o         (full),
        .empty_o        (empty)
    );

    always #5 clk = ~clk;

    // Reference time base: number of rising edges since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 64'd1;
    end

    // Classifier sweep table, buffered during the fill test.
    logic [31:0]  tbl_i  [16] = '{
        32'h30200073, 32'h02B50533, 32'h00004501, 32'h00000013,
        32'h00B5050B, 32'h0000006F, 32'h00008067, 32'h00B50463,
        32'h30047073, 32'h0FF0000F, 32'h00B5302F, 32'h0005B507,
        32'h00A5B027, 32'h02B57553, 32'h00B50533, 32'h02B5053B};
    logic         tbl_ex [16] = '{0,0,0,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    trace_class_e tbl_c  [16] = '{
        CLS_SYS,   CLS_MULDIV, CLS_COMPR, CLS_EXC,
        CLS_SUBFP, CLS_JUMP,   CLS_JUMP,  CLS_BRANCH,
        CLS_CSR,   CLS_SYS,    CLS_AMO,   CLS_FP,
        CLS_FP,    CLS_FP,     CLS_OTHER, CLS_MULDIV};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s: %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] tpc(input int j);
        return 64'h8000_1000 + 64'(4 * j);
    endfunction

    // Drive both commit ports for one cycle; keep marks which commits are expected to survive.
    task automatic commit2(input logic [1:0] v, input logic [1:0] ex,
                           input logic [31:0] i0, input logic [31:0] i1,
                           input logic [63:0] pc0, input logic [63:0] pc1,
                           input logic [1:0] keep,
                           input trace_class_e c0, input trace_class_e c1);
        commit_valid = v;
        commit_ex    = ex;
        commit_instr = {i1, i0};
        commit_pc    = {pc1, pc0};
        if (keep[0]) exp_q.push_back('{pc: pc0, instr: i0, cls: c0, port: 2'd0, cycle: cyc});
        if (keep[1]) exp_q.push_back('{pc: pc1, instr: i1, cls: c1, port: 2'd1, cycle: cyc});
        tick();
        commit_valid = '0;
        commit_ex    = '0;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (!rst && trace_valid && trace_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop%0d: unexpected entry pc=%h instr=%h, want none", pop_idx, trace_pc, trace_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if (trace_pc === mon_e.pc && trace_instr === mon_e.instr &&
                    trace_class === 4'(mon_e.cls) && trace_port === mon_e.port &&
                    trace_cycle === mon_e.cycle) begin
                    n_pass++;
                    $display("ok   pop%0d: pc=%h instr=%h cls=%0d port=%0d cyc=%0d",
                             pop_idx, trace_pc, trace_instr, trace_class, trace_port, trace_cycle);
                end else begin
                    $display("FAIL pop%0d: got pc=%h instr=%h cls=%0d port=%0d cyc=%0d, want pc=%h instr=%h cls=%0d port=%0d cyc=%0d",
                             pop_idx, trace_pc, trace_instr, trace_class, trace_port, trace_cycle,
                             mon_e.pc, mon_e.instr, 4'(mon_e.cls), mon_e.port, mon_e.cycle);
                end
            end
            pop_idx++;
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_valid",   64'(trace_valid), 64'd0);
        chk("rst_empty",   64'(empty),       64'd1);
        chk("rst_full",    64'(full),        64'd0);
        chk("rst_dropped", 64'(dropped_cnt), 64'd0);
        chk("rst_pc",      trace_pc,         64'd0);
        chk("rst_cycle",   trace_cycle,      64'd0);
        chk("rst_class",   64'(trace_class), 64'd0);
        rst = 1'b0;

        // Single commit in cycle 5, visible next cycle with stamp 5
        repeat (5) tick();
        commit2(2'b01, 2'b00, 32'h00000013, 32'h0, 64'h8000_0000, 64'h0, 2'b01, CLS_OTHER, CLS_OTHER);
        chk("t1_valid", 64'(trace_valid), 64'd1);
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        chk("t1_empty", 64'(empty), 64'd1);

        // Dual commit LW + SW, same stamp, port order preserved
        commit2(2'b11, 2'b00, 32'h0002A303, 32'h0062A023, 64'h8000_0004, 64'h8000_0008,
                2'b11, CLS_LOAD, CLS_STORE);
        trace_ready = 1'b1;
        repeat (2) tick();
        trace_ready = 1'b0;
        chk("t2_empty", 64'(empty), 64'd1);

        // Fill 15 with the classifier sweep, then 2 commits: port1 is dropped
        for (int j = 0; j < 7; j++) begin
            commit2(2'b11, {tbl_ex[2*j+1], tbl_ex[2*j]}, tbl_i[2*j], tbl_i[2*j+1],
                    tpc(2*j), tpc(2*j+1), 2'b11, tbl_c[2*j], tbl_c[2*j+1]);
        end
        commit2(2'b01, {1'b0, tbl_ex[14]}, tbl_i[14], 32'h0, tpc(14), 64'h0, 2'b01, tbl_c[14], CLS_OTHER);
        chk("t3_full_at15", 64'(full), 64'd0);
        commit2(2'b11, {1'b0, tbl_ex[15]}, tbl_i[15], 32'h00000013, tpc(15), tpc(99),
                2'b01, tbl_c[15], CLS_OTHER);
        chk("t3_full",    64'(full),        64'd1);
        chk("t3_dropped", 64'(dropped_cnt), 64'd1);

        // Full + pop + commit in one cycle: pop happens, commit dropped
        trace_ready = 1'b1;
        commit2(2'b01, 2'b00, 32'h00000013, 32'h0, tpc(100), 64'h0, 2'b00, CLS_OTHER, CLS_OTHER);
        trace_ready = 1'b0;
        chk("t4_dropped", 64'(dropped_cnt), 64'd2);
        chk("t4_full",    64'(full),        64'd0);
        chk("t4_valid",   64'(trace_valid), 64'd1);

        // Drain 9 to leave 6 buffered
        trace_ready = 1'b1;
        repeat (9) tick();
        trace_ready = 1'b0;
        chk("t5_pre_empty", 64'(empty), 64'd0);

        // Flush with 2 commits in the same cycle
        flush = 1'b1;
        commit2(2'b11, 2'b00, 32'h00000013, 32'h00000013, tpc(200), tpc(201), 2'b00, CLS_OTHER, CLS_OTHER);
        flush = 1'b0;
        exp_q.delete();
        chk("t5_empty",   64'(empty),       64'd1);
        chk("t5_valid",   64'(trace_valid), 64'd0);
        chk("t5_dropped", 64'(dropped_cnt), 64'd2);

        // Port 1 alone after flush lands in slot 0 and reports port 1
        commit2(2'b10, 2'b00, 32'h0, 32'h0062A023, 64'h0, tpc(300), 2'b10, CLS_OTHER, CLS_STORE);
        trace_ready = 1'b1;
        repeat (3) tick();
        trace_ready = 1'b0;
        chk("t6_empty", 64'(empty), 64'd1);

        chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
